// File: rtl/accel_mem_pkg.sv
// Shared types and constants for the accelerator memory server:
// FSM state encoding, write-status codes and the read-return FIFO depth.
package accel_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_READ       = 2'd1,
    ST_WRITE_DATA = 2'd2,
    ST_WRITE_RESP = 2'd3
  } state_e;

  localparam logic STATUS_OK  = 1'b1;
  localparam logic STATUS_ERR = 1'b0;

  localparam int RBUF_DEPTH = 2;

  // A burst is writable only when its byte address is word aligned.
  function automatic logic addr_status(input logic [1:0] byte_lsb);
    return (byte_lsb == 2'b00) ? STATUS_OK : STATUS_ERR;
  endfunction

endpackage

// File: rtl/accel_mem_server_if.sv
// Bundle of the request/response channels and the SRAM port of accel_mem_server.
// slave = memory server side, master = accelerator + SRAM side.
interface accel_mem_server_if #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int MEM_AWIDTH = 12
) ();

  logic [AWIDTH-1:0]     req_read_addr;
  logic                  req_read_addr_valid;
  logic                  req_read_addr_ready;
  logic [31:0]           req_read_len;
  logic [DWIDTH-1:0]     rdata;
  logic                  rdata_valid;
  logic                  rdata_ready;

  logic [AWIDTH-1:0]     req_write_addr;
  logic                  req_write_addr_valid;
  logic                  req_write_addr_ready;
  logic [31:0]           req_write_len;
  logic [DWIDTH-1:0]     req_write_data;
  logic                  req_write_data_valid;
  logic                  req_write_data_ready;
  logic                  resp_write_status;
  logic                  resp_write_status_valid;
  logic                  resp_write_status_ready;

  logic [MEM_AWIDTH-1:0] mem_addr;
  logic                  mem_en;
  logic                  mem_we;
  logic [DWIDTH-1:0]     mem_din;
  logic [DWIDTH-1:0]     mem_dout;

  modport slave (
    input  req_read_addr, req_read_addr_valid, req_read_len, rdata_ready,
    output req_read_addr_ready, rdata, rdata_valid,
    input  req_write_addr, req_write_addr_valid, req_write_len,
    input  req_write_data, req_write_data_valid, resp_write_status_ready,
    output req_write_addr_ready, req_write_data_ready,
    output resp_write_status, resp_write_status_valid,
    output mem_addr, mem_en, mem_we, mem_din,
    input  mem_dout
  );

  modport master (
    output req_read_addr, req_read_addr_valid, req_read_len, rdata_ready,
    input  req_read_addr_ready, rdata, rdata_valid,
    output req_write_addr, req_write_addr_valid, req_write_len,
    output req_write_data, req_write_data_valid, resp_write_status_ready,
    input  req_write_addr_ready, req_write_data_ready,
    input  resp_write_status, resp_write_status_valid,
    input  mem_addr, mem_en, mem_we, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/accel_mem_rbuf.sv
// Two-entry read-return FIFO with fall-through: an arriving word is presented
// on the output in the same cycle when the FIFO is empty.
module accel_mem_rbuf
  import accel_mem_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic [DWIDTH-1:0] buf_q [RBUF_DEPTH];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;
  logic              empty;
  logic              push;
  logic              pop;

  assign empty     = (count_q == 2'd0);
  assign out_valid = !empty || in_valid;
  assign out_data  = !empty ? buf_q[rd_ptr_q] : (in_valid ? in_data : '0);
  assign pop       = !empty && out_ready;
  // A word taken directly by the consumer while empty never enters storage.
  assign push      = in_valid && !(empty && out_ready);
  assign occupancy = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/accel_mem_server.sv
// Burst read/write responder in front of a single-port synchronous SRAM.
// Optional ACCEL_MEM_SERVER_STATS_EN adds read/write word counters.
module accel_mem_server
  import accel_mem_pkg::*;
#(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int MEM_AWIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  accel_mem_server_if.slave    bus
`ifdef ACCEL_MEM_SERVER_STATS_EN
  ,
  output logic [31:0]          stat_read_words,
  output logic [31:0]          stat_write_words
`endif
);

  state_e                state_q, state_d;
  logic                  prefer_read_q;
  logic [MEM_AWIDTH-1:0] idx_q;
  logic [31:0]           issue_left_q;
  logic [31:0]           beats_left_q;
  logic                  wstatus_q;
  logic                  rd_vld_p1;

  logic                  grant_read;
  logic                  grant_write;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  issue;
  logic                  beat_fire;
  logic                  wbeat_fire;
  logic                  mem_write;
  logic [2:0]            credit_used;
  logic [1:0]            occ;
  logic                  rb_valid;
  logic [DWIDTH-1:0]     rb_data;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^{bus.req_read_addr[AWIDTH-1:MEM_AWIDTH+2],
                              bus.req_read_addr[1:0],
                              bus.req_write_addr[AWIDTH-1:MEM_AWIDTH+2]};

  // Loser of the last contested arbitration wins the next one.
  assign grant_read  = bus.req_read_addr_valid &&
                       (!bus.req_write_addr_valid || prefer_read_q);
  assign grant_write = bus.req_write_addr_valid && !grant_read;
  assign rd_acc      = (state_q == ST_IDLE) && grant_read;
  assign wr_acc      = (state_q == ST_IDLE) && grant_write;

  assign credit_used = {1'b0, occ} + {2'b00, rd_vld_p1};
  assign issue       = (state_q == ST_READ) && (issue_left_q != 32'd0) &&
                       (credit_used < 3'd2);
  assign beat_fire   = (state_q == ST_READ) && rb_valid && bus.rdata_ready;
  assign wbeat_fire  = (state_q == ST_WRITE_DATA) && bus.req_write_data_valid;
  assign mem_write   = wbeat_fire && (wstatus_q == STATUS_OK);

  accel_mem_rbuf #(.DWIDTH(DWIDTH)) u_rbuf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_vld_p1),
    .in_data   (bus.mem_dout),
    .out_valid (rb_valid),
    .out_ready (bus.rdata_ready),
    .out_data  (rb_data),
    .occupancy (occ)
  );

  always_comb begin
    state_d                     = state_q;
    bus.req_read_addr_ready     = 1'b0;
    bus.req_write_addr_ready    = 1'b0;
    bus.req_write_data_ready    = 1'b0;
    bus.resp_write_status_valid = 1'b0;
    bus.resp_write_status       = STATUS_ERR;
    bus.rdata_valid             = rb_valid;
    bus.rdata                   = rb_data;
    bus.mem_en                  = issue || mem_write;
    bus.mem_we                  = mem_write;
    bus.mem_addr                = (issue || mem_write) ? idx_q : '0;
    bus.mem_din                 = mem_write ? bus.req_write_data : '0;
    case (state_q)
      ST_IDLE: begin
        bus.req_read_addr_ready  = grant_read;
        bus.req_write_addr_ready = grant_write;
        if (rd_acc)
          state_d = ST_READ;
        else if (wr_acc)
          state_d = (bus.req_write_len == 32'd0) ? ST_WRITE_RESP : ST_WRITE_DATA;
      end
      ST_READ: begin
        if ((beats_left_q == 32'd0) || (beat_fire && beats_left_q == 32'd1))
          state_d = ST_IDLE;
      end
      ST_WRITE_DATA: begin
        bus.req_write_data_ready = 1'b1;
        if (wbeat_fire && beats_left_q == 32'd1)
          state_d = ST_WRITE_RESP;
      end
      ST_WRITE_RESP: begin
        bus.resp_write_status_valid = 1'b1;
        bus.resp_write_status       = wstatus_q;
        if (bus.resp_write_status_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // p0 -> p1: an SRAM read issued this cycle returns data next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      prefer_read_q <= 1'b1;
      issue_left_q  <= '0;
      beats_left_q  <= '0;
      wstatus_q     <= STATUS_ERR;
      rd_vld_p1     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_vld_p1 <= issue;
      if (state_q == ST_IDLE && bus.req_read_addr_valid && bus.req_write_addr_valid)
        prefer_read_q <= !grant_read;
      if (rd_acc) begin
        issue_left_q <= bus.req_read_len;
        beats_left_q <= bus.req_read_len;
      end else if (wr_acc) begin
        beats_left_q <= bus.req_write_len;
        wstatus_q    <= addr_status(bus.req_write_addr[1:0]);
      end else begin
        if (issue) issue_left_q <= issue_left_q - 32'd1;
        if (beat_fire || wbeat_fire) beats_left_q <= beats_left_q - 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_acc)
      idx_q <= bus.req_read_addr[MEM_AWIDTH+1:2];
    else if (wr_acc)
      idx_q <= bus.req_write_addr[MEM_AWIDTH+1:2];
    else if (issue || wbeat_fire)
      idx_q <= idx_q + MEM_AWIDTH'(1);
  end

`ifdef ACCEL_MEM_SERVER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_read_words  <= '0;
      stat_write_words <= '0;
    end else begin
      if (beat_fire) stat_read_words  <= stat_read_words + 32'd1;
      if (mem_write) stat_write_words <= stat_write_words + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_accel_mem_server.sv
// Directed, table-driven bench for accel_mem_server with a behavioural SRAM.
module tb_accel_mem_server;

  logic clk;
  logic rst;
  int   cyc;
  int   n_pass;
  int   n_chk;

  accel_mem_server_if #(.AWIDTH(32), .DWIDTH(32), .MEM_AWIDTH(12)) bus ();

`ifdef ACCEL_MEM_SERVER_STATS_EN
  logic [31:0] stat_read_words;
  logic [31:0] stat_write_words;
`endif

  accel_mem_server #(.AWIDTH(32), .DWIDTH(32), .MEM_AWIDTH(12)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ACCEL_MEM_SERVER_STATS_EN
    ,
    .stat_read_words  (stat_read_words),
    .stat_write_words (stat_write_words)
`endif
  );

  logic [31:0] sram [0:4095];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) sram[bus.mem_addr] <= bus.mem_din;
      else            bus.mem_dout <= sram[bus.mem_addr];
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d required < 20000", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
  endtask

  task automatic timeout_fail(input string nm);
    n_chk++;
    $display("FAIL %s: timeout waiting for handshake (actual none, required one)", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".rd_addr_ready"}, {31'd0, bus.req_read_addr_ready}, 32'd0);
    chk({nm, ".wr_addr_ready"}, {31'd0, bus.req_write_addr_ready}, 32'd0);
    chk({nm, ".wr_data_ready"}, {31'd0, bus.req_write_data_ready}, 32'd0);
    chk({nm, ".rdata_valid"},   {31'd0, bus.rdata_valid}, 32'd0);
    chk({nm, ".rdata"},         bus.rdata, 32'd0);
    chk({nm, ".resp_valid"},    {31'd0, bus.resp_write_status_valid}, 32'd0);
    chk({nm, ".resp_status"},   {31'd0, bus.resp_write_status}, 32'd0);
    chk({nm, ".mem_en"},        {31'd0, bus.mem_en}, 32'd0);
    chk({nm, ".mem_we"},        {31'd0, bus.mem_we}, 32'd0);
    chk({nm, ".mem_addr"},      {20'd0, bus.mem_addr}, 32'd0);
  endtask

  // Entered and left at posedge+1.
  task automatic run_read(input string nm, input logic [31:0] addr, input int len,
                          input bit stall, input logic [3:0][31:0] d);
    int w, acc_cyc, first_cyc, last_cyc, got;
    bus.req_read_addr       = addr;
    bus.req_read_len        = len;
    bus.req_read_addr_valid = 1'b1;
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.req_read_addr_ready) break;
      tick();
    end
    if (w == 20) begin
      timeout_fail({nm, ".accept"});
      tick();
      bus.req_read_addr_valid = 1'b0;
      return;
    end
    acc_cyc   = cyc;
    first_cyc = 0;
    last_cyc  = 0;
    tick();
    bus.req_read_addr_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && got < len; k++) begin
      bus.rdata_ready = stall ? k[0] : 1'b1;
      @(negedge clk);
      if (bus.rdata_valid && bus.rdata_ready) begin
        chk($sformatf("%s.beat%0d", nm, got), bus.rdata, d[got]);
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      tick();
    end
    chk({nm, ".beat_count"}, got, len);
    if (!stall && len > 0) begin
      chk({nm, ".first_latency"}, first_cyc - acc_cyc, 32'd2);
      chk({nm, ".back_to_back"}, last_cyc - first_cyc, len - 1);
    end
    bus.rdata_ready = 1'b1;
    @(negedge clk);
    chk({nm, ".no_extra_beat"}, {31'd0, bus.rdata_valid}, 32'd0);
    tick();
    bus.rdata_ready = 1'b0;
  endtask

  task automatic run_write(input string nm, input logic [31:0] addr, input int len,
                           input logic [3:0][31:0] d, input bit exp_status, input int hold);
    int w, acc_cyc;
    bus.req_write_addr       = addr;
    bus.req_write_len        = len;
    bus.req_write_addr_valid = 1'b1;
    bus.resp_write_status_ready = 1'b0;
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus.req_write_addr_ready) break;
      tick();
    end
    if (w == 20) begin
      timeout_fail({nm, ".accept"});
      tick();
      bus.req_write_addr_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    tick();
    bus.req_write_addr_valid = 1'b0;
    for (int b = 0; b < len; b++) begin
      bus.req_write_data       = d[b];
      bus.req_write_data_valid = 1'b1;
      for (w = 0; w < 20; w++) begin
        @(negedge clk);
        if (bus.req_write_data_ready) break;
        tick();
      end
      if (w == 20) begin
        timeout_fail($sformatf("%s.beat%0d", nm, b));
        bus.req_write_data_valid = 1'b0;
        return;
      end
      if (b == 0) chk({nm, ".data_ready_at_T+1"}, cyc - acc_cyc, 32'd1);
      tick();
    end
    bus.req_write_data_valid = 1'b0;
    @(negedge clk);
    chk({nm, ".resp_valid_next_cycle"}, {31'd0, bus.resp_write_status_valid}, 32'd1);
    chk({nm, ".resp_status"}, {31'd0, bus.resp_write_status}, {31'd0, exp_status});
    for (int h = 0; h < hold; h++) begin
      tick();
      @(negedge clk);
      chk($sformatf("%s.hold%0d_valid", nm, h), {31'd0, bus.resp_write_status_valid}, 32'd1);
      chk($sformatf("%s.hold%0d_status", nm, h), {31'd0, bus.resp_write_status}, {31'd0, exp_status});
    end
    tick();
    bus.resp_write_status_ready = 1'b1;
    tick();
    bus.resp_write_status_ready = 1'b0;
    @(negedge clk);
    chk({nm, ".resp_released"}, {31'd0, bus.resp_write_status_valid}, 32'd0);
    tick();
  endtask

  typedef struct {
    bit              is_wr;
    logic [31:0]     addr;
    int              len;
    bit              stall;
    int              hold;
    logic [3:0][31:0] d;      // d[0] is the first beat
    bit              exp_status;
  } vec_t;

  localparam logic [31:0] A = 32'hA0A0_A0A0;
  localparam logic [31:0] B = 32'hB0B0_B0B0;
  localparam logic [31:0] C = 32'hC0C0_C0C0;

  vec_t tbl [10];

  initial begin
    n_pass = 0;
    n_chk  = 0;
    for (int i = 0; i < 4096; i++) sram[i] = 32'h0;
    sram[12'h010] = 32'd1;
    sram[12'h011] = 32'd2;
    sram[12'h012] = 32'd3;
    sram[12'h013] = 32'd4;
    sram[12'hFFF] = 32'h55;
    sram[12'h000] = 32'h66;

    tbl[0] = '{0, 32'h40,   4, 0, 0, {32'd4, 32'd3, 32'd2, 32'd1}, 0};
    tbl[1] = '{0, 32'h40,   4, 1, 0, {32'd4, 32'd3, 32'd2, 32'd1}, 0};
    tbl[2] = '{1, 32'h80,   3, 0, 3, {32'd0, C, B, A}, 1};
    tbl[3] = '{0, 32'h80,   3, 0, 0, {32'd0, C, B, A}, 0};
    tbl[4] = '{1, 32'h82,   2, 0, 0, {32'd0, 32'd0, 32'hE0E0_E0E0, 32'hD0D0_D0D0}, 0};
    tbl[5] = '{0, 32'h80,   2, 1, 0, {32'd0, 32'd0, B, A}, 0};
    tbl[6] = '{0, 32'h43,   2, 0, 0, {32'd0, 32'd0, 32'd2, 32'd1}, 0};
    tbl[7] = '{0, 32'h40,   0, 0, 0, {32'd0, 32'd0, 32'd0, 32'd0}, 0};
    tbl[8] = '{1, 32'h100,  0, 0, 1, {32'd0, 32'd0, 32'd0, 32'd0}, 1};
    tbl[9] = '{0, 32'h3FFC, 2, 1, 0, {32'd0, 32'd0, 32'h66, 32'h55}, 0};

    rst = 1'b1;
    bus.req_read_addr = '0;  bus.req_read_addr_valid = 1'b0;  bus.req_read_len = '0;
    bus.rdata_ready = 1'b0;
    bus.req_write_addr = '0; bus.req_write_addr_valid = 1'b0; bus.req_write_len = '0;
    bus.req_write_data = '0; bus.req_write_data_valid = 1'b0;
    bus.resp_write_status_ready = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk_reset_vals("reset");
    tick();
    rst = 1'b0;

    // Contested arbitration straight after reset: read first, then write.
    bus.req_read_addr = 32'h40;   bus.req_read_len = 0;  bus.req_read_addr_valid = 1'b1;
    bus.req_write_addr = 32'h100; bus.req_write_len = 0; bus.req_write_addr_valid = 1'b1;
    bus.resp_write_status_ready = 1'b1;
    @(negedge clk);
    chk("arb1.read_ready",  {31'd0, bus.req_read_addr_ready}, 32'd1);
    chk("arb1.write_ready", {31'd0, bus.req_write_addr_ready}, 32'd0);
    tick();
    bus.req_read_addr_valid = 1'b0;
    @(negedge clk);
    chk("arb1.no_ready_in_read", {31'd0, bus.req_write_addr_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("arb1.write_next", {31'd0, bus.req_write_addr_ready}, 32'd1);
    tick();
    bus.req_write_addr_valid = 1'b0;
    @(negedge clk);
    chk("arb1.resp_valid", {31'd0, bus.resp_write_status_valid}, 32'd1);
    tick();
    @(negedge clk);
    tick();
    bus.req_read_addr_valid  = 1'b1;
    bus.req_write_addr_valid = 1'b1;
    @(negedge clk);
    chk("arb2.write_ready", {31'd0, bus.req_write_addr_ready}, 32'd1);
    chk("arb2.read_ready",  {31'd0, bus.req_read_addr_ready}, 32'd0);
    tick();
    bus.req_write_addr_valid = 1'b0;
    @(negedge clk);
    chk("arb2.resp_valid", {31'd0, bus.resp_write_status_valid}, 32'd1);
    chk("arb2.read_blocked", {31'd0, bus.req_read_addr_ready}, 32'd0);
    tick();
    @(negedge clk);
    chk("arb2.read_next", {31'd0, bus.req_read_addr_ready}, 32'd1);
    tick();
    bus.req_read_addr_valid = 1'b0;
    bus.resp_write_status_ready = 1'b0;
    tick(); tick();

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].is_wr)
        run_write($sformatf("v%0d", i), tbl[i].addr, tbl[i].len, tbl[i].d,
                  tbl[i].exp_status, tbl[i].hold);
      else
        run_read($sformatf("v%0d", i), tbl[i].addr, tbl[i].len, tbl[i].stall, tbl[i].d);
    end
    chk("mem20", sram[12'h020], A);
    chk("mem21", sram[12'h021], B);
    chk("mem22", sram[12'h022], C);

    // Reset in the middle of a stalled read, then a fresh request.
    bus.req_read_addr = 32'h40; bus.req_read_len = 4; bus.req_read_addr_valid = 1'b1;
    bus.rdata_ready = 1'b0;
    begin
      int w;
      for (w = 0; w < 20; w++) begin
        @(negedge clk);
        if (bus.req_read_addr_ready) break;
        tick();
      end
      if (w == 20) timeout_fail("midrst.accept");
    end
    tick();
    bus.req_read_addr_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("midrst");
    tick();
    bus.rdata_ready = 1'b1;
    @(negedge clk);
    chk("midrst.stale_discarded", {31'd0, bus.rdata_valid}, 32'd0);
    tick();
    bus.rdata_ready = 1'b0;
    run_read("after_rst", 32'h40, 2, 0, {32'd0, 32'd0, 32'd2, 32'd1});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
